pu_riscv_ahb3_arbiter: RTL and testbench

- Fixed-priority AHB3-Lite arbiter that shares one downstream AHB3-Lite slave port between the three masters of the RISC-V processing unit: instruction fetch (ins), data (dat) and debug (dbg).
- Tracks address-phase and data-phase ownership separately, so transfers from different masters pipeline back to back.
- Stalls losing masters by driving their HREADY low.
- Sits between the processing unit and the SoC interconnect.

---
 rtl/pu_riscv_ahb3_arbiter.sv | 161 ++++++++++++++++
 tb/tb_pu_riscv_ahb3_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_riscv_ahb3_arbiter.sv
// Fixed-priority (dbg > dat > ins) AHB3-Lite arbiter sharing one slave port
// between the three processing-unit masters, with separate address/data-phase ownership.
module pu_riscv_ahb3_arbiter #(
  parameter int PLEN        = 32,
  parameter int XLEN        = 32,
  parameter int PARK_MASTER = 0,
  parameter int HSIZE_SIZE  = 3,
  parameter int HBURST_SIZE = 3,
  parameter int HPROT_SIZE  = 4,
  parameter int HTRANS_SIZE = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESET,

  input  logic                   ins_HSEL,
  input  logic [PLEN-1:0]        ins_HADDR,
  input  logic [XLEN-1:0]        ins_HWDATA,
  input  logic                   ins_HWRITE,
  input  logic [HSIZE_SIZE-1:0]  ins_HSIZE,
  input  logic [HBURST_SIZE-1:0] ins_HBURST,
  input  logic [HPROT_SIZE-1:0]  ins_HPROT,
  input  logic [HTRANS_SIZE-1:0] ins_HTRANS,
  input  logic                   ins_HMASTLOCK,
  output logic [XLEN-1:0]        ins_HRDATA,
  output logic                   ins_HREADY,
  output logic                   ins_HRESP,

  input  logic                   dat_HSEL,
  input  logic [PLEN-1:0]        dat_HADDR,
  input  logic [XLEN-1:0]        dat_HWDATA,
  input  logic                   dat_HWRITE,
  input  logic [HSIZE_SIZE-1:0]  dat_HSIZE,
  input  logic [HBURST_SIZE-1:0] dat_HBURST,
  input  logic [HPROT_SIZE-1:0]  dat_HPROT,
  input  logic [HTRANS_SIZE-1:0] dat_HTRANS,
  input  logic                   dat_HMASTLOCK,
  output logic [XLEN-1:0]        dat_HRDATA,
  output logic                   dat_HREADY,
  output logic                   dat_HRESP,

  input  logic                   dbg_HSEL,
  input  logic [PLEN-1:0]        dbg_HADDR,
  input  logic [XLEN-1:0]        dbg_HWDATA,
  input  logic                   dbg_HWRITE,
  input  logic [HSIZE_SIZE-1:0]  dbg_HSIZE,
  input  logic [HBURST_SIZE-1:0] dbg_HBURST,
  input  logic [HPROT_SIZE-1:0]  dbg_HPROT,
  input  logic [HTRANS_SIZE-1:0] dbg_HTRANS,
  input  logic                   dbg_HMASTLOCK,
  output logic [XLEN-1:0]        dbg_HRDATA,
  output logic                   dbg_HREADY,
  output logic                   dbg_HRESP,

  output logic                   HSEL,
  output logic [PLEN-1:0]        HADDR,
  output logic [XLEN-1:0]        HWDATA,
  output logic                   HWRITE,
  output logic [HSIZE_SIZE-1:0]  HSIZE,
  output logic [HBURST_SIZE-1:0] HBURST,
  output logic [HPROT_SIZE-1:0]  HPROT,
  output logic [HTRANS_SIZE-1:0] HTRANS,
  output logic                   HMASTLOCK,
  input  logic [XLEN-1:0]        HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP,

  output logic [1:0]             gnt_o
);

  // Master slot 3 is unused and tied idle so an out-of-range grant selects nothing.
  logic [3:0]             hsel_a, hwrite_a, hlock_a;
  logic [PLEN-1:0]        haddr_a  [4];
  logic [XLEN-1:0]        hwdata_a [4];
  logic [HSIZE_SIZE-1:0]  hsize_a  [4];
  logic [HBURST_SIZE-1:0] hburst_a [4];
  logic [HPROT_SIZE-1:0]  hprot_a  [4];
  logic [HTRANS_SIZE-1:0] htrans_a [4];

  assign hsel_a   = {1'b0, dbg_HSEL, dat_HSEL, ins_HSEL};
  assign hwrite_a = {1'b0, dbg_HWRITE, dat_HWRITE, ins_HWRITE};
  assign hlock_a  = {1'b0, dbg_HMASTLOCK, dat_HMASTLOCK, ins_HMASTLOCK};
  assign haddr_a  = '{ins_HADDR,  dat_HADDR,  dbg_HADDR,  '0};
  assign hwdata_a = '{ins_HWDATA, dat_HWDATA, dbg_HWDATA, '0};
  assign hsize_a  = '{ins_HSIZE,  dat_HSIZE,  dbg_HSIZE,  '0};
  assign hburst_a = '{ins_HBURST, dat_HBURST, dbg_HBURST, '0};
  assign hprot_a  = '{ins_HPROT,  dat_HPROT,  dbg_HPROT,  '0};
  assign htrans_a = '{ins_HTRANS, dat_HTRANS, dbg_HTRANS, '0};

  logic [1:0] gnt, gnt_nxt, dph_owner;
  logic       dph_valid;
  logic [2:0] req, rdy, resp;
  logic       hold;

  assign req[0] = ins_HSEL & ins_HTRANS[1];
  assign req[1] = dat_HSEL & dat_HTRANS[1];
  assign req[2] = dbg_HSEL & dbg_HTRANS[1];

  // HTRANS[0] is set for BUSY (01) and SEQ (11): the owner is mid-burst.
  assign hold = htrans_a[gnt][0] | hlock_a[gnt];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    gnt_nxt = gnt;
    if (!hold) begin
      if      (req[2]) gnt_nxt = 2'd2;
      else if (req[1]) gnt_nxt = 2'd1;
      else if (req[0]) gnt_nxt = 2'd0;
    end
  end

  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (HRESET) begin
      gnt       <= 2'(PARK_MASTER);
      dph_owner <= 2'(PARK_MASTER);
      dph_valid <= 1'b0;
    end else if (HREADY) begin
      gnt       <= gnt_nxt;
      dph_owner <= gnt;
      dph_valid <= HTRANS[1] & HSEL;
    end
  end

  assign gnt_o     = gnt;
  assign HSEL      = hsel_a[gnt];
  assign HTRANS    = hsel_a[gnt] ? htrans_a[gnt] : '0;
  assign HADDR     = haddr_a[gnt];
  assign HWRITE    = hwrite_a[gnt];
  assign HSIZE     = hsize_a[gnt];
  assign HBURST    = hburst_a[gnt];
  assign HPROT     = hprot_a[gnt];
  assign HMASTLOCK = hlock_a[gnt];
  assign HWDATA    = hwdata_a[dph_owner];

  // Losing requesters are stalled so their address stays stable until granted.
  always_comb begin
    rdy  = '1;
    resp = '0;
    for (int m = 0; m < 3; m++) begin
      if (dph_valid && dph_owner == 2'(m)) begin
        rdy[m]  = HREADY;
        resp[m] = HRESP;
      end else if (gnt == 2'(m)) begin
        rdy[m]  = HREADY;
      end else if (req[m]) begin
        rdy[m]  = 1'b0;
      end
    end
  end

  assign ins_HREADY = rdy[0];
  assign dat_HREADY = rdy[1];
  assign dbg_HREADY = rdy[2];
  assign ins_HRESP  = resp[0];
  assign dat_HRESP  = resp[1];
  assign dbg_HRESP  = resp[2];
  assign ins_HRDATA = HRDATA;
  assign dat_HRDATA = HRDATA;
  assign dbg_HRDATA = HRDATA;

endmodule

// File: tb/tb_pu_riscv_ahb3_arbiter.sv
// Directed bench for pu_riscv_ahb3_arbiter; read data phases are checked
// against a scoreboard filled when each address phase is accepted.
module tb_pu_riscv_ahb3_arbiter;

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        m_hsel   [3];
  logic        m_hwrite [3];
  logic        m_hlock  [3];
  logic [31:0] m_haddr  [3];
  logic [31:0] m_hwdata [3];
  logic [2:0]  m_hsize  [3];
  logic [2:0]  m_hburst [3];
  logic [3:0]  m_hprot  [3];
  logic [1:0]  m_htrans [3];
  logic [31:0] m_hrdata [3];
  logic        m_hready [3];
  logic        m_hresp  [3];

  logic        b_hsel, b_hwrite, b_hlock;
  logic [31:0] b_haddr, b_hwdata;
  logic [2:0]  b_hsize, b_hburst;
  logic [3:0]  b_hprot;
  logic [1:0]  b_htrans;
  logic [31:0] slv_hrdata;
  logic        slv_hready, slv_hresp;
  logic [1:0]  gnt_o;

  typedef struct packed { logic [1:0] mst; logic [31:0] data; } sb_t;
  sb_t sb [$];

  int n_tests = 0;
  int n_fail  = 0;

  pu_riscv_ahb3_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .ins_HSEL(m_hsel[0]), .ins_HADDR(m_haddr[0]), .ins_HWDATA(m_hwdata[0]),
    .ins_HWRITE(m_hwrite[0]), .ins_HSIZE(m_hsize[0]), .ins_HBURST(m_hburst[0]),
    .ins_HPROT(m_hprot[0]), .ins_HTRANS(m_htrans[0]), .ins_HMASTLOCK(m_hlock[0]),
    .ins_HRDATA(m_hrdata[0]), .ins_HREADY(m_hready[0]), .ins_HRESP(m_hresp[0]),
    .dat_HSEL(m_hsel[1]), .dat_HADDR(m_haddr[1]), .dat_HWDATA(m_hwdata[1]),
    .dat_HWRITE(m_hwrite[1]), .dat_HSIZE(m_hsize[1]), .dat_HBURST(m_hburst[1]),
    .dat_HPROT(m_hprot[1]), .dat_HTRANS(m_htrans[1]), .dat_HMASTLOCK(m_hlock[1]),
    .dat_HRDATA(m_hrdata[1]), .dat_HREADY(m_hready[1]), .dat_HRESP(m_hresp[1]),
    .dbg_HSEL(m_hsel[2]), .dbg_HADDR(m_haddr[2]), .dbg_HWDATA(m_hwdata[2]),
    .dbg_HWRITE(m_hwrite[2]), .dbg_HSIZE(m_hsize[2]), .dbg_HBURST(m_hburst[2]),
    .dbg_HPROT(m_hprot[2]), .dbg_HTRANS(m_htrans[2]), .dbg_HMASTLOCK(m_hlock[2]),
    .dbg_HRDATA(m_hrdata[2]), .dbg_HREADY(m_hready[2]), .dbg_HRESP(m_hresp[2]),
    .HSEL(b_hsel), .HADDR(b_haddr), .HWDATA(b_hwdata), .HWRITE(b_hwrite),
    .HSIZE(b_hsize), .HBURST(b_hburst), .HPROT(b_hprot), .HTRANS(b_htrans),
    .HMASTLOCK(b_hlock), .HRDATA(slv_hrdata), .HREADY(slv_hready), .HRESP(slv_hresp),
    .gnt_o(gnt_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic lk, input logic [2:0] burst);
    m_hsel[m]   = 1'b1;
    m_htrans[m] = tr;
    m_haddr[m]  = a;
    m_hwrite[m] = wr;
    m_hlock[m]  = lk;
    m_hburst[m] = burst;
  endtask

  task automatic idle(input int m);
    m_hsel[m]   = 1'b0;
    m_htrans[m] = IDLE;
    m_hwrite[m] = 1'b0;
    m_hlock[m]  = 1'b0;
  endtask

  task automatic push_rd(input logic [1:0] m, input logic [31:0] d);
    sb.push_back('{mst: m, data: d});
  endtask

  // Slave model presents the read data of the oldest outstanding read.
  task automatic serve();
    if (sb.size() > 0) slv_hrdata = sb[0].data;
  endtask

  task automatic dph_check();
    sb_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("rdata_m%0d", e.mst), m_hrdata[e.mst], e.data);
      check($sformatf("rdata_rdy_m%0d", e.mst), 32'(m_hready[e.mst]), 32'd1);
    end
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    HRESET = 1'b1;
    slv_hready = 1'b1;
    slv_hresp  = 1'b0;
    slv_hrdata = 32'h0;
    for (int m = 0; m < 3; m++) begin
      idle(m);
      m_haddr[m] = 32'h0;
      m_hsize[m] = 3'b010;
      m_hburst[m] = SINGLE;
      m_hprot[m] = 4'b0011;
    end
    m_hwdata[0] = 32'h1111_1111;
    m_hwdata[1] = 32'h2222_2222;
    m_hwdata[2] = 32'h3333_3333;

    // 1: reset
    repeat (2) @(posedge HCLK);
    #1; mid();
    check("rst_gnt", 32'(gnt_o), 0);
    check("rst_htrans", 32'(b_htrans), 0);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("rst_rdy_m%0d", m), 32'(m_hready[m]), 1);
      check($sformatf("rst_resp_m%0d", m), 32'(m_hresp[m]), 0);
    end
    tick();
    HRESET = 1'b0;

    // 2: ins alone, zero-wait read
    drv(0, NSEQ, 32'h0000_0200, 1'b0, 1'b0, SINGLE);
    mid();
    check("t2_haddr", b_haddr, 32'h0000_0200);
    check("t2_htrans", 32'(b_htrans), 32'(NSEQ));
    check("t2_ins_rdy", 32'(m_hready[0]), 1);
    push_rd(2'd0, 32'h1234_5678);
    tick();
    idle(0); serve();
    mid();
    dph_check();
    check("t2_idle_htrans", 32'(b_htrans), 0);
    tick();

    // 3: ins and dat request together, ins owns the address phase
    drv(0, NSEQ, 32'h0000_0200, 1'b0, 1'b0, SINGLE);
    drv(1, NSEQ, 32'h8000_0000, 1'b0, 1'b0, INCR4);
    mid();
    check("t3_haddr_ins", b_haddr, 32'h0000_0200);
    check("t3_dat_stall", 32'(m_hready[1]), 0);
    check("t3_ins_rdy", 32'(m_hready[0]), 1);
    push_rd(2'd0, 32'hA5A5_0001);
    tick();
    // 4: dat INCR4 burst, beat 1 (NONSEQ)
    idle(0); serve();
    mid();
    dph_check();
    check("t3_gnt", 32'(gnt_o), 1);
    check("t3_haddr_dat", b_haddr, 32'h8000_0000);
    check("t3_dat_rdy", 32'(m_hready[1]), 1);
    push_rd(2'd1, 32'hD000_0000);
    tick();
    for (int b = 1; b < 4; b++) begin
      drv(1, SEQ, 32'h8000_0000 + 32'(4 * b), 1'b0, 1'b0, INCR4);
      drv(2, NSEQ, 32'h4000_0000, 1'b0, 1'b0, SINGLE);
      serve();
      mid();
      dph_check();
      check($sformatf("t4_gnt_b%0d", b + 1), 32'(gnt_o), 1);
      check($sformatf("t4_haddr_b%0d", b + 1), b_haddr, 32'h8000_0000 + 32'(4 * b));
      check($sformatf("t4_dbg_stall_b%0d", b + 1), 32'(m_hready[2]), 0);
      push_rd(2'd1, 32'hD000_0000 + 32'(b));
      tick();
    end
    idle(1); serve();
    mid();
    dph_check();
    check("t4_gnt_post", 32'(gnt_o), 1);
    check("t4_dbg_stall_post", 32'(m_hready[2]), 0);
    tick();
    mid();
    check("t4_gnt_dbg", 32'(gnt_o), 2);
    check("t4_haddr_dbg", b_haddr, 32'h4000_0000);
    check("t4_dbg_rdy", 32'(m_hready[2]), 1);
    push_rd(2'd2, 32'hDB60_0000);
    tick();
    idle(2); serve();
    mid();
    dph_check();
    tick();

    // 5: dat write with two wait states then a two-cycle ERROR
    drv(1, NSEQ, 32'h8000_0100, 1'b1, 1'b0, SINGLE);
    mid();
    check("t5_dat_stall", 32'(m_hready[1]), 0);
    tick();
    mid();
    check("t5_gnt", 32'(gnt_o), 1);
    check("t5_haddr", b_haddr, 32'h8000_0100);
    check("t5_hwrite", 32'(b_hwrite), 1);
    tick();
    idle(1);
    m_hwdata[1] = 32'hCAFE_F00D;
    slv_hready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      slv_hready = (c == 3);
      slv_hresp  = (c >= 2);
      mid();
      check($sformatf("t5_hwdata_c%0d", c), b_hwdata, 32'hCAFE_F00D);
      check($sformatf("t5_dat_rdy_c%0d", c), 32'(m_hready[1]), 32'(c == 3));
      check($sformatf("t5_dat_resp_c%0d", c), 32'(m_hresp[1]), 32'(c >= 2));
      check($sformatf("t5_ins_resp_c%0d", c), 32'(m_hresp[0]), 0);
      check($sformatf("t5_dbg_resp_c%0d", c), 32'(m_hresp[2]), 0);
      tick();
    end
    mid();
    check("t5_resp_after", 32'(m_hresp[1]), 0);
    tick();
    slv_hresp = 1'b0;

    // 6: dbg locked sequence while ins requests, then reset mid-sequence
    drv(2, NSEQ, 32'h4000_0010, 1'b0, 1'b1, SINGLE);
    drv(0, NSEQ, 32'h0000_0300, 1'b0, 1'b0, SINGLE);
    mid();
    check("t6_dbg_stall", 32'(m_hready[2]), 0);
    check("t6_ins_stall0", 32'(m_hready[0]), 0);
    tick();
    mid();
    check("t6_gnt_a", 32'(gnt_o), 2);
    check("t6_hlock", 32'(b_hlock), 1);
    check("t6_ins_stall1", 32'(m_hready[0]), 0);
    push_rd(2'd2, 32'hDB60_0010);
    tick();
    drv(2, NSEQ, 32'h4000_0014, 1'b0, 1'b1, SINGLE);
    serve();
    mid();
    dph_check();
    check("t6_gnt_b", 32'(gnt_o), 2);
    check("t6_haddr_b", b_haddr, 32'h4000_0014);
    push_rd(2'd2, 32'hDB60_0014);
    tick();
    drv(2, IDLE, 32'h4000_0018, 1'b0, 1'b1, SINGLE);
    serve();
    mid();
    dph_check();
    check("t6_ins_stall2", 32'(m_hready[0]), 0);
    tick();
    mid();
    check("t6_gnt_locked", 32'(gnt_o), 2);
    check("t6_ins_stall3", 32'(m_hready[0]), 0);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    idle(2);
    mid();
    check("t6_gnt_rst", 32'(gnt_o), 0);
    check("t6_haddr_ins", b_haddr, 32'h0000_0300);
    check("t6_ins_rdy", 32'(m_hready[0]), 1);
    push_rd(2'd0, 32'h0300_0300);
    tick();
    idle(0); serve();
    mid();
    dph_check();
    check("sb_drained", 32'(sb.size()), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
